// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the command, external-ALU and result signals of alu_cmd_issuer.
// The slave modport is the issuer's view. The master modport is the
// environment's view: the command source, the ALU and the result sink.
interface alu_cmd_issuer_if #(
  parameter int DATA_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [2:0]        cmd_sel;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic [7:0]        op_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_err, op_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_err, op_count
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands in a small FIFO and issues them one at a time to an
// external combinational ALU. Each result is held until the sink accepts it.
//
//   state | meaning
//   IDLE  | waiting for a buffered command; pops the head when one is present
//   ISSUE | operands are on alu_a/alu_b/alu_sel; alu_out is captured next edge
//   HOLD  | result presented on res_*; waits for res_ready
module alu_cmd_issuer #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_issuer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem_a   [DEPTH];
  logic [DATA_W-1:0] mem_b   [DEPTH];
  logic [2:0]        mem_sel [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  // Ready comes from the registered occupancy only, so a same-cycle pop never
  // lets a write into a full FIFO.
  assign bus.cmd_ready = (count < CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == IDLE) && (count != '0);

  // FIFO storage and pointers. The payload needs no reset; count gates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_a[wr_ptr]   <= bus.cmd_a;
        mem_b[wr_ptr]   <= bus.cmd_b;
        mem_sel[wr_ptr] <= bus.cmd_sel;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered ALU operands and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_sel   <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_err   <= 1'b0;
      bus.op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.alu_a   <= mem_a[rd_ptr];
            bus.alu_b   <= mem_b[rd_ptr];
            bus.alu_sel <= mem_sel[rd_ptr];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Opcodes 101-111 are illegal: report an error with a zero result.
          if (bus.alu_sel > 3'd4) begin
            bus.res_data <= '0;
            bus.res_err  <= 1'b1;
          end else begin
            bus.res_data <= bus.alu_out;
            bus.res_err  <= 1'b0;
          end
          bus.res_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.op_count  <= bus.op_count + 8'd1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed testbench for alu_cmd_issuer. It uses a behavioural model of the
// external ALU and checks results against hand-computed values.
module tb_alu_cmd_issuer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_cmd_issuer_if #(.DATA_W(4)) bus ();

  alu_cmd_issuer #(.DATA_W(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The external ALU. Illegal opcodes return 4'h9, which the issuer must not pass on.
  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
    case (sel)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      default: return 4'h9;
    endcase
  endfunction

  assign bus.alu_out = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    logic acc;
    acc           = 1'b0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = bus.cmd_ready;
      tick();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50; i++) begin
      if (bus.res_valid) break;
      tick();
    end
    if (!bus.res_valid) chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_result(input string tag, input logic [3:0] exp_data, input logic exp_err);
    wait_valid();
    chk({tag, "_data"}, 32'(bus.res_data), 32'(exp_data));
    chk({tag, "_err"}, 32'(bus.res_err), 32'(exp_err));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  logic [3:0] q_a   [5];
  logic [3:0] q_b   [5];
  logic [3:0] q_exp [5];

  initial begin
    int idx;
    int highs;
    int hs;
    logic acc;
    logic was_valid;

    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Values right after reset.
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_err",   32'(bus.res_err),   32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
    chk("rst_alu_b",     32'(bus.alu_b),     32'd0);
    chk("rst_alu_sel",   32'(bus.alu_sel),   32'd0);
    chk("rst_op_count",  32'(bus.op_count),  32'd0);

    // 3 + 5 = 8. The result is valid after the second edge that follows
    // the acceptance edge.
    bus.res_ready = 1'b1;
    bus.cmd_a = 4'd3; bus.cmd_b = 4'd5; bus.cmd_sel = 3'b000; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("lat_e0_valid", 32'(bus.res_valid), 32'd0);
    tick();
    chk("lat_e1_valid", 32'(bus.res_valid), 32'd0);
    chk("lat_e1_alu_a", 32'(bus.alu_a), 32'd3);
    chk("lat_e1_alu_b", 32'(bus.alu_b), 32'd5);
    tick();
    chk("lat_e2_valid", 32'(bus.res_valid), 32'd1);
    chk("add_data",     32'(bus.res_data),  32'd8);
    chk("add_err",      32'(bus.res_err),   32'd0);
    tick();
    chk("add_valid_clr", 32'(bus.res_valid), 32'd0);
    chk("add_op_count",  32'(bus.op_count),  32'd1);
    bus.res_ready = 1'b0;

    // Each legal opcode, then one illegal opcode.
    send(4'd2, 4'd3, 3'b001);   get_result("sub", 4'hF, 1'b0);
    send(4'hA, 4'd0, 3'b100);   get_result("not", 4'h5, 1'b0);
    send(4'hC, 4'hA, 3'b010);   get_result("and", 4'h8, 1'b0);
    send(4'hC, 4'hA, 3'b011);   get_result("or",  4'hE, 1'b0);
    send(4'd7, 4'd1, 3'b110);   get_result("ill", 4'h0, 1'b1);
    chk("alu_sel_hold", 32'(bus.alu_sel), 32'd6);
    chk("op_count_6",   32'(bus.op_count), 32'd6);

    // Backpressure: with res_ready low, six commands are offered back to back.
    q_a[0] = 4'd1; q_b[0] = 4'd1; q_exp[0] = 4'd2;
    q_a[1] = 4'd2; q_b[1] = 4'd3; q_exp[1] = 4'd5;
    q_a[2] = 4'd4; q_b[2] = 4'd4; q_exp[2] = 4'd8;
    q_a[3] = 4'd6; q_b[3] = 4'd1; q_exp[3] = 4'd7;
    q_a[4] = 4'd9; q_b[4] = 4'd5; q_exp[4] = 4'hE;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      bus.cmd_a     = (idx < 5) ? q_a[idx] : 4'hF;
      bus.cmd_b     = (idx < 5) ? q_b[idx] : 4'hF;
      bus.cmd_sel   = 3'b000;
      bus.cmd_valid = 1'b1;
      acc = bus.cmd_ready;
      tick();
      if (acc) idx++;
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepted",  32'(idx), 32'd5);
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("bp_hold_valid", 32'(bus.res_valid), 32'd1);
    chk("bp_hold_data",  32'(bus.res_data),  32'd2);
    for (int k = 0; k < 5; k++) begin
      get_result($sformatf("bp_res%0d", k), q_exp[k], 1'b0);
    end
    chk("bp_op_count", 32'(bus.op_count), 32'd11);

    // Reset while in HOLD with three commands still buffered.
    send(4'd1, 4'd2, 3'b000);
    send(4'd3, 4'd3, 3'b000);
    send(4'd5, 4'd1, 3'b000);
    send(4'd2, 4'd2, 3'b000);
    wait_valid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mrst_op_count",  32'(bus.op_count),  32'd0);
    chk("mrst_res_data",  32'(bus.res_data),  32'd0);
    bus.res_ready = 1'b1;
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.res_valid) highs++;
      tick();
    end
    chk("mrst_no_stale", 32'(highs), 32'd0);

    // 256 completed handshakes bring op_count back to 0.
    bus.cmd_a = 4'd1; bus.cmd_b = 4'd1; bus.cmd_sel = 3'b000; bus.cmd_valid = 1'b1;
    hs = 0;
    for (int k = 0; k < 3000 && hs < 256; k++) begin
      was_valid = bus.res_valid;
      tick();
      if (was_valid) begin
        hs++;
        if (hs == 255) chk("wrap_255", 32'(bus.op_count), 32'd255);
      end
    end
    bus.cmd_valid = 1'b0;
    chk("wrap_handshakes", 32'(hs), 32'd256);
    chk("wrap_op_count", 32'(bus.op_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
